// File: rtl/axi4lite_regbank.sv
// axi4lite_regbank: parametrised AXI4-Lite register bank with read-only status registers and access strobes
module axi4lite_regbank #(
    parameter int                 DW      = 32,
    parameter int                 AW      = 8,
    parameter int                 REG_NUM = 8,
    parameter logic [REG_NUM-1:0] RO_MASK = '0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [AW-1:0]         awaddr,
    input  logic                  awvalid,
    output logic                  awready,
    input  logic [DW-1:0]         wdata,
    input  logic [DW/8-1:0]       wstrb,
    input  logic                  wvalid,
    output logic                  wready,
    output logic [1:0]            bresp,
    output logic                  bvalid,
    input  logic                  bready,
    input  logic [AW-1:0]         araddr,
    input  logic                  arvalid,
    output logic                  arready,
    output logic [DW-1:0]         rdata,
    output logic [1:0]            rresp,
    output logic                  rvalid,
    input  logic                  rready,
    output logic [REG_NUM*DW-1:0] regs_out,
    input  logic [REG_NUM*DW-1:0] regs_in,
    output logic [REG_NUM-1:0]    wr_pulse,
    output logic [REG_NUM-1:0]    rd_pulse
);
    localparam int SW = DW / 8;
    localparam int LB = $clog2(SW);
    localparam int IW = AW - LB;

    logic [REG_NUM-1:0][DW-1:0] regs_q, regs_d;
    logic aw_held_q, aw_held_d, w_held_q, w_held_d, bvalid_q, bvalid_d, rvalid_q, rvalid_d;
    logic [IW-1:0] aw_idx_q, aw_idx_d;
    logic [DW-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
    logic [SW-1:0] wstrb_q, wstrb_d;
    logic [1:0] bresp_q, bresp_d, rresp_q, rresp_d;
    logic [REG_NUM-1:0] wr_pulse_q, wr_pulse_d, rd_pulse_q, rd_pulse_d;
    logic aw_hs, w_hs, ar_hs, commit;
    logic [IW-1:0] w_idx, r_idx;
    logic [DW-1:0] w_data, r_val;
    logic [SW-1:0] w_strb;
    logic unused_addr_lsb;

    assign awready = ~aw_held_q & ~bvalid_q;
    assign wready = ~w_held_q & ~bvalid_q;
    assign arready = ~rvalid_q;
    assign bvalid = bvalid_q;
    assign bresp = bresp_q;
    assign rvalid = rvalid_q;
    assign rdata = rdata_q;
    assign rresp = rresp_q;
    assign wr_pulse = wr_pulse_q;
    assign rd_pulse = rd_pulse_q;
    assign unused_addr_lsb = ^{awaddr[LB-1:0], araddr[LB-1:0]};

    always_comb begin
        aw_hs = awvalid & awready;
        w_hs = wvalid & wready;
        ar_hs = arvalid & arready;
        commit = (aw_held_q | aw_hs) & (w_held_q | w_hs) & ~bvalid_q;
        w_idx = aw_held_q ? aw_idx_q : awaddr[AW-1:LB];
        w_data = w_held_q ? wdata_q : wdata;
        w_strb = w_held_q ? wstrb_q : wstrb;
        r_idx = araddr[AW-1:LB];
        r_val = '0;
        regs_d = regs_q;
        wr_pulse_d = '0;
        rd_pulse_d = '0;
        // Out-of-range or read-only targets match no writable slot, so they fall out as SLVERR
        for (int i = 0; i < REG_NUM; i++) begin
            wr_pulse_d[i] = commit & (w_idx == IW'(i)) & ~RO_MASK[i];
            rd_pulse_d[i] = ar_hs & (r_idx == IW'(i));
            if (rd_pulse_d[i]) r_val = RO_MASK[i] ? regs_in[i*DW +: DW] : regs_q[i];
            for (int k = 0; k < SW; k++)
                if (wr_pulse_d[i] & w_strb[k]) regs_d[i][k*8 +: 8] = w_data[k*8 +: 8];
        end
        aw_held_d = ~commit & (aw_held_q | aw_hs);
        aw_idx_d = aw_hs ? awaddr[AW-1:LB] : aw_idx_q;
        w_held_d = ~commit & (w_held_q | w_hs);
        wdata_d = w_hs ? wdata : wdata_q;
        wstrb_d = w_hs ? wstrb : wstrb_q;
        bvalid_d = commit | (bvalid_q & ~bready);
        bresp_d = commit ? ((|wr_pulse_d) ? 2'b00 : 2'b10) : bresp_q;
        rvalid_d = ar_hs | (rvalid_q & ~rready);
        rdata_d = ar_hs ? r_val : rdata_q;
        rresp_d = ar_hs ? ((|rd_pulse_d) ? 2'b00 : 2'b10) : rresp_q;
    end

    always_comb begin
        regs_out = '0;
        for (int i = 0; i < REG_NUM; i++) regs_out[i*DW +: DW] = RO_MASK[i] ? '0 : regs_q[i];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            regs_q <= '0;
            aw_held_q <= 1'b0;
            aw_idx_q <= '0;
            w_held_q <= 1'b0;
            wdata_q <= '0;
            wstrb_q <= '0;
            bvalid_q <= 1'b0;
            bresp_q <= 2'b00;
            rvalid_q <= 1'b0;
            rdata_q <= '0;
            rresp_q <= 2'b00;
            wr_pulse_q <= '0;
            rd_pulse_q <= '0;
        end else begin
            regs_q <= regs_d;
            aw_held_q <= aw_held_d;
            aw_idx_q <= aw_idx_d;
            w_held_q <= w_held_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            bvalid_q <= bvalid_d;
            bresp_q <= bresp_d;
            rvalid_q <= rvalid_d;
            rdata_q <= rdata_d;
            rresp_q <= rresp_d;
            wr_pulse_q <= wr_pulse_d;
            rd_pulse_q <= rd_pulse_d;
        end
    end
endmodule

// File: tb/tb_axi4lite_regbank.sv
// tb_axi4lite_regbank: directed and random AXI4-Lite traffic against an array-based register model
module tb_axi4lite_regbank;
    localparam logic [7:0] RO = 8'h80;

    logic clk = 1'b0, reset_n = 1'b0;
    logic [7:0] awaddr = '0, araddr = '0;
    logic awvalid = 1'b0, wvalid = 1'b0, bready = 1'b1, arvalid = 1'b0, rready = 1'b0;
    logic [31:0] wdata = '0;
    logic [3:0] wstrb = '0;
    logic awready, wready, bvalid, arready, rvalid;
    logic [1:0] bresp, rresp;
    logic [31:0] rdata;
    logic [255:0] regs_out, regs_in = '0;
    logic [7:0] wr_pulse, rd_pulse;
    logic [31:0] mregs [8];
    int n_cmp = 0, n_bad = 0;

    axi4lite_regbank #(.DW(32), .AW(8), .REG_NUM(8), .RO_MASK(RO)) dut (
        .clk(clk), .reset_n(reset_n),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .regs_out(regs_out), .regs_in(regs_in), .wr_pulse(wr_pulse), .rd_pulse(rd_pulse)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] exp_out();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = RO[i] ? 32'h0 : mregs[i];
        return r;
    endfunction

    // gap > 0: W leads AW by gap cycles; gap < 0: AW leads W; 0: same cycle
    task automatic do_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s, input int gap);
        logic [5:0] ia = a[7:2];
        logic ok = (ia < 6'd8) && !RO[ia[2:0]];
        int ag = gap < 0 ? -gap : gap;
        if (gap >= 0) begin wdata = d; wstrb = s; wvalid = 1'b1; end
        if (gap <= 0) begin awaddr = a; awvalid = 1'b1; end
        for (int i = 0; i < ag; i++) begin
            @(negedge clk);
            awvalid = 1'b0;
            wvalid = 1'b0;
            check("wait_bvalid", bvalid, 0);
            check("wait_awready", awready, gap > 0);
            check("wait_wready", wready, gap < 0);
        end
        if (gap > 0) begin awaddr = a; awvalid = 1'b1; end
        if (gap < 0) begin wdata = d; wstrb = s; wvalid = 1'b1; end
        @(negedge clk);
        awvalid = 1'b0;
        wvalid = 1'b0;
        if (ok) for (int k = 0; k < 4; k++) if (s[k]) mregs[ia[2:0]][k*8 +: 8] = d[k*8 +: 8];
        check("b_valid", bvalid, 1);
        check("b_resp", bresp, ok ? 2'b00 : 2'b10);
        check("wr_pulse", wr_pulse, ok ? (8'b1 << ia[2:0]) : 8'h00);
        check("regs_out", regs_out, exp_out());
        @(negedge clk);
        check("b_done", bvalid, 0);
        check("wr_pulse_end", wr_pulse, 0);
    endtask

    task automatic do_read(input logic [7:0] a, input int hold);
        logic [5:0] ia = a[7:2];
        logic in_r = ia < 6'd8;
        logic [31:0] ed = !in_r ? 32'h0 : RO[ia[2:0]] ? regs_in[ia[2:0]*32 +: 32] : mregs[ia[2:0]];
        logic [7:0] ep = in_r ? (8'b1 << ia[2:0]) : 8'h00;
        logic [1:0] er = in_r ? 2'b00 : 2'b10;
        araddr = a;
        arvalid = 1'b1;
        @(negedge clk);
        arvalid = 1'b0;
        check("r_valid", rvalid, 1);
        check("r_data", rdata, ed);
        check("r_resp", rresp, er);
        check("rd_pulse", rd_pulse, ep);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("r_hold_valid", rvalid, 1);
            check("r_hold_data", rdata, ed);
            check("r_hold_resp", rresp, er);
            check("r_hold_arready", arready, 0);
            check("r_hold_pulse", rd_pulse, 0);
        end
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
        check("r_done", rvalid, 0);
        check("r_arready", arready, 1);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) mregs[i] = '0;
        repeat (2) @(negedge clk);
        check("rst_bvalid", bvalid, 0);
        check("rst_rvalid", rvalid, 0);
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_ready", {awready, wready, arready}, 3'b111);
        check("rst_regs", regs_out, 0);
        check("rst_pulses", {wr_pulse, rd_pulse}, 0);

        do_write(8'h04, 32'hDEADBEEF, 4'hF, 0);
        check("reg1_value", regs_out[63:32], 32'hDEADBEEF);
        do_write(8'h08, 32'h11223344, 4'b0101, 3);
        check("reg2_value", regs_out[95:64], 32'h00220044);
        do_write(8'h1C, 32'h12345678, 4'hF, -2);
        regs_in[255:224] = 32'hCAFE0001;
        do_read(8'h1C, 0);
        do_read(8'h20, 5);
        do_read(8'h06, 1);

        fork
            do_write(8'h0C, 32'h55, 4'hF, 0);
            do_read(8'h0C, 0);
        join
        do_read(8'h0C, 0);

        // Reset with a pending write response
        bready = 1'b0;
        awaddr = 8'h10; awvalid = 1'b1;
        wdata = 32'h12345678; wstrb = 4'hF; wvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0;
        wvalid = 1'b0;
        check("pre_rst_bvalid", bvalid, 1);
        #2 reset_n = 1'b0;
        #1;
        check("async_bvalid", bvalid, 0);
        check("async_regs", regs_out, 0);
        check("async_wr_pulse", wr_pulse, 0);
        for (int i = 0; i < 8; i++) mregs[i] = '0;
        @(negedge clk);
        reset_n = 1'b1;
        bready = 1'b1;
        // Reset while an address is held must discard it
        awaddr = 8'h14; awvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0;
        #2 reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        wdata = 32'hA5A5_5A5A; wstrb = 4'hF; wvalid = 1'b1;
        @(negedge clk);
        wvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("w_alone_bvalid", bvalid, 0);
            check("w_alone_pulse", wr_pulse, 0);
            check("w_alone_awready", awready, 1);
            @(negedge clk);
        end
        awaddr = 8'h18; awvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0;
        mregs[6] = 32'hA5A5_5A5A;
        check("late_aw_bvalid", bvalid, 1);
        check("late_aw_pulse", wr_pulse, 8'h40);
        check("late_aw_regs", regs_out, exp_out());
        @(negedge clk);

        for (int n = 0; n < 60; n++) begin
            logic [7:0] a;
            a = 8'(($urandom_range(0, 9) << 2) | $urandom_range(0, 3));
            for (int i = 0; i < 8; i++) regs_in[i*32 +: 32] = $urandom;
            if ($urandom_range(0, 1) == 1) do_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 6) - 3);
            else do_read(a, $urandom_range(0, 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
